usr_shift_sequencer: RTL and testbench

//  Command-driven controller for the 4-bit universal shift register (USR: ctrl 00 hold, 01 shift left, 10 shift right, 11 parallel load).
//  - Accepts one command per valid/ready handshake: optional parallel load, then N shifts in one direction with a chosen fill bit.
//  - Drives the USR ctrl/d inputs for exactly the needed cycles, samples q and reports completion.
//  - Sits between the host/control logic and the USR; the USR itself has no reset, so this block owns all sequencing of it.

---
 rtl/usr_shift_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_sequencer.sv
// ----------------------------------------------------------------------------
// usr_shift_sequencer
//   Command-driven sequencer for a WIDTH-bit universal shift register (USR).
//   One command = optional parallel load followed by cmd_count shifts in one
//   direction with a chosen serial fill bit. The block drives the USR ctrl/d
//   inputs for exactly the cycles needed, then captures q as the result.
//   USR ctrl encoding: 00 hold, 01 shift left, 10 shift right, 11 load.
//
// Configuration macro:
//   USR_SEQ_CMD_QUEUE_EN - adds a 2-entry command FIFO in front of the FSM;
//                          cmd_ready then reflects FIFO space in any state and
//                          DONE chains straight into the next queued command.
//                          Undefined (default): single command register,
//                          cmd_ready only in IDLE.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_load            parallel-load cmd_data before shifting
//   cmd_dir             0 = shift left, 1 = shift right
//   cmd_fill            serial bit shifted in on every shift
//   cmd_count           number of shift cycles
//   cmd_data            load value
//   usr_ctrl, usr_d     to the USR
//   usr_q               from the USR
//   busy                command in progress
//   done                one-cycle pulse, result valid
//   result              usr_q captured at completion, held until next done
// ----------------------------------------------------------------------------
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic             cmd_dir,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       usr_ctrl,
    output logic [WIDTH-1:0] usr_d,
    input  logic [WIDTH-1:0] usr_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             load;
        logic             dir;
        logic             fill;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] data;
    } cmd_t;

    state_t           state_r;
    state_t           state_nxt_s;
    cmd_t             cmd_r;
    cmd_t             in_cmd_s;
    cmd_t             src_cmd_s;
    logic             src_valid_s;
    logic             take_s;
    logic             ready_s;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;

    // First state a freshly taken command enters.
    function automatic state_t first_state(input cmd_t c);
        if (c.load) begin
            return ST_LOAD;
        end else if (c.count != {CNT_W{1'b0}}) begin
            return ST_SHIFT;
        end else begin
            return ST_DONE;
        end
    endfunction

    assign in_cmd_s = {cmd_load, cmd_dir, cmd_fill, cmd_count, cmd_data};

`ifdef USR_SEQ_CMD_QUEUE_EN
    cmd_t       fifo_mem_r [2];
    logic       wr_ptr_r;
    logic       rd_ptr_r;
    logic [1:0] fifo_cnt_r;
    logic       push_s;

    assign push_s      = cmd_valid && ready_s;
    assign src_valid_s = (fifo_cnt_r != 2'd0);
    assign src_cmd_s   = fifo_mem_r[rd_ptr_r];

    // Two-entry command FIFO; the FSM pops through take_s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= in_cmd_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (take_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, take_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end
`else
    assign src_valid_s = cmd_valid;
    assign src_cmd_s   = in_cmd_s;
`endif

    // State, command, counter and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cmd_r    <= '0;
            cnt_r    <= {CNT_W{1'b0}};
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (take_s) begin
                cmd_r <= src_cmd_s;
            end
            // Counter loads on SHIFT entry; the count comes straight from the
            // source when entry coincides with taking the command.
            if ((state_nxt_s == ST_SHIFT) && (state_r != ST_SHIFT)) begin
                cnt_r <= take_s ? src_cmd_s.count : cmd_r.count;
            end else if ((state_r == ST_SHIFT) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            done_r <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                result_r <= usr_q;
            end
        end
    end

    // Next-state logic and command take strobe.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (src_valid_s) begin
                    take_s      = 1'b1;
                    state_nxt_s = first_state(src_cmd_s);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cmd_r.count != {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
`ifdef USR_SEQ_CMD_QUEUE_EN
                if (src_valid_s) begin
                    take_s      = 1'b1;
                    state_nxt_s = first_state(src_cmd_s);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from state and the registered command.
    always_comb begin
        usr_ctrl = 2'b00;
        usr_d    = {WIDTH{1'b0}};
        case (state_r)
            ST_LOAD: begin
                usr_ctrl = 2'b11;
                usr_d    = cmd_r.data;
            end
            ST_SHIFT: begin
                if (cmd_r.dir) begin
                    usr_ctrl         = 2'b10;
                    usr_d[WIDTH-1]   = cmd_r.fill;
                end else begin
                    usr_ctrl         = 2'b01;
                    usr_d[0]         = cmd_r.fill;
                end
            end
            default: begin
                usr_ctrl = 2'b00;
                usr_d    = {WIDTH{1'b0}};
            end
        endcase
`ifdef USR_SEQ_CMD_QUEUE_EN
        ready_s = (fifo_cnt_r != 2'd2);
`else
        ready_s = (state_r == ST_IDLE);
`endif
    end

    assign cmd_ready = ready_s;
    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign result    = result_r;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
module tb_usr_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic       cmd_dir = 1'b0;
    logic       cmd_fill = 1'b0;
    logic [2:0] cmd_count = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [1:0] usr_ctrl;
    logic [3:0] usr_d;
    logic [3:0] usr_q = 4'b0000;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [3:0] res;
        int         edge_no;
        int         shifts;
        int         loads;
        int         busy_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_q = 4'b0000;
    int         shift_seen = 0;
    int         load_seen  = 0;
    int         busy_seen  = 0;

    usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_dir   (cmd_dir),
        .cmd_fill  (cmd_fill),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .usr_ctrl  (usr_ctrl),
        .usr_d     (usr_d),
        .usr_q     (usr_q),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Universal shift register: no reset, holds its contents.
    always @(posedge clk) begin
        case (usr_ctrl)
            2'b01:   usr_q <= {usr_q[2:0], usr_d[0]};
            2'b10:   usr_q <= {usr_d[3], usr_q[3:1]};
            2'b11:   usr_q <= usr_d;
            default: usr_q <= usr_q;
        endcase
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] usr_model(input logic [3:0] q, input logic ld, input logic dir,
                                             input logic fill, input int n, input logic [3:0] data);
        logic [3:0] r;
        r = ld ? data : q;
        for (int i = 0; i < n; i++) begin
            r = dir ? {fill, r[3:1]} : {r[2:0], fill};
        end
        return r;
    endfunction

    // Scoreboard consumer and per-command activity counters.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {28'd0, result}, {28'd0, e.res});
                    check("done_latency", edge_cnt, e.edge_no);
                    check("shift_cycles", shift_seen, e.shifts);
                    check("load_cycles", load_seen, e.loads);
                    check("busy_cycles", busy_seen, e.busy_cyc);
                end
                shift_seen = 0;
                load_seen  = 0;
                busy_seen  = 0;
            end
            if (usr_ctrl == 2'b01 || usr_ctrl == 2'b10) shift_seen++;
            if (usr_ctrl == 2'b11) load_seen++;
            if (busy) busy_seen++;
`ifndef USR_SEQ_CMD_QUEUE_EN
            check("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
`endif
        end
    end

    // Present a command, wait for acceptance (bounded), push expectation.
    task automatic send(input logic ld, input logic dir, input logic fill,
                        input logic [2:0] cnt, input logic [3:0] data);
        exp_t e;
        int   w;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_dir   = dir;
        cmd_fill  = fill;
        cmd_count = cnt;
        cmd_data  = data;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            check("accept_in_idle", {31'd0, busy}, 32'd0);
            exp_q      = usr_model(exp_q, ld, dir, fill, int'(cnt), data);
            e.res      = exp_q;
            e.edge_no  = edge_cnt + 1 + 1 + int'(ld) + int'(cnt);
            e.shifts   = int'(cnt);
            e.loads    = int'(ld);
            e.busy_cyc = 1 + int'(ld) + int'(cnt);
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic release_valid();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 80) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ctrl",   {30'd0, usr_ctrl}, 32'd0);
        check("rst_d",      {28'd0, usr_d}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_ready",  {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;

        // Load 1101, one left shift with fill 0 -> 1010.
        send(1'b1, 1'b0, 1'b0, 3'd1, 4'b1101);
        release_valid();
        check("t1_ctrl_load", {30'd0, usr_ctrl}, 32'd3);
        check("t1_d_load",    {28'd0, usr_d}, 32'hD);
        @(negedge clk);
        check("t1_ctrl_shl",  {30'd0, usr_ctrl}, 32'd1);
        check("t1_d_shl",     {28'd0, usr_d}, 32'd0);
        wait_drain();

        // Load 1101, two right shifts with fill 1 -> 1111.
        send(1'b1, 1'b1, 1'b1, 3'd2, 4'b1101);
        release_valid();
        @(negedge clk);
        check("t2_ctrl_shr",  {30'd0, usr_ctrl}, 32'd2);
        check("t2_d_shr",     {28'd0, usr_d}, 32'h8);
        wait_drain();

        // Load with zero shifts, then a bare zero-count command.
        send(1'b1, 1'b0, 1'b1, 3'd0, 4'b0110);
        release_valid();
        wait_drain();
        send(1'b0, 1'b1, 1'b1, 3'd0, 4'b1111);
        release_valid();
        wait_drain();

        // Valid held high across two commands: second waits for IDLE.
        send(1'b1, 1'b0, 1'b1, 3'd3, 4'b0001);
        send(1'b0, 1'b1, 1'b0, 3'd2, 4'b0000);
        release_valid();
        wait_drain();

        // Random commands, some back-to-back.
        for (int i = 0; i < 10; i++) begin
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if (i % 3 == 2) begin
                release_valid();
                wait_drain();
            end
        end
        release_valid();
        wait_drain();

        // Reset during the third shift cycle of a 7-shift command.
        send(1'b1, 1'b0, 1'b0, 3'd7, 4'b1001);
        release_valid();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_ctrl",   {30'd0, usr_ctrl}, 32'd0);
        check("mid_rst_busy",   {31'd0, busy}, 32'd0);
        check("mid_rst_done",   {31'd0, done}, 32'd0);
        check("mid_rst_result", {28'd0, result}, 32'd0);
        check("mid_rst_ready",  {31'd0, cmd_ready}, 32'd1);
        sb.delete();
        shift_seen = 0;
        load_seen  = 0;
        busy_seen  = 0;
        exp_q = usr_model(4'b0000, 1'b1, 1'b0, 1'b0, 2, 4'b1001);
        @(negedge clk);
        reset = 1'b0;
        // USR kept its partially shifted contents through the reset.
        send(1'b0, 1'b0, 1'b0, 3'd0, 4'b0000);
        release_valid();
        wait_drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
